mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/bitserial_mac_pkg.sv | 20 ++
 rtl/sat_adder.sv | 31 +++
 rtl/mac_accumulator.sv | 141 ++++++++++++++
 tb/tb_mac_accumulator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitserial_mac_pkg.sv
// Shared types and default sizing for the bit-serial MAC datapath
// (accumulator and the upstream sequential multiplier).
package bitserial_mac_pkg;

  localparam int DEF_PRODUCT_WIDTH = 8;
  localparam int DEF_ACC_WIDTH     = 16;
  localparam int DEF_MAX_TERMS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } mac_state_e;

  // Width needed to represent a term count of 0..max_terms.
  function automatic int term_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned saturating adder: ACC_WIDTH accumulator plus a zero-extended
// PRODUCT_WIDTH operand, clamped to all-ones on carry-out.
module sat_adder #(
  parameter int ACC_WIDTH     = 16,
  parameter int PRODUCT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0]     acc,
  input  logic [PRODUCT_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]     sum,
  output logic                     sat
);

  logic [ACC_WIDTH-1:0] product_ext;
  logic [ACC_WIDTH:0]   raw_sum;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_zext
      if (gi < PRODUCT_WIDTH) begin : g_bit
        assign product_ext[gi] = product[gi];
      end else begin : g_zero
        assign product_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign raw_sum = {1'b0, acc} + {1'b0, product_ext};
  assign sat     = raw_sum[ACC_WIDTH];
  assign sum     = sat ? {ACC_WIDTH{1'b1}} : raw_sum[ACC_WIDTH-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a programmed number of unsigned products with saturation and
// presents the sum through a valid/ready handshake.
module mac_accumulator
  import bitserial_mac_pkg::*;
#(
  parameter int  PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int  ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int  MAX_TERMS     = DEF_MAX_TERMS,
  localparam int TERM_WIDTH    = $clog2(MAX_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TERM_WIDTH-1:0]    num_terms,
  input  logic [PRODUCT_WIDTH-1:0] product,
  input  logic                     product_valid,
  output logic [ACC_WIDTH-1:0]     result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy,
  output logic                     overflow,
  output logic                     dropped
);

  localparam logic [TERM_WIDTH-1:0] MAX_TERMS_T = TERM_WIDTH'(MAX_TERMS);

  mac_state_e            state_reg, state_next;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic [TERM_WIDTH-1:0] count_reg, count_next;
  logic [TERM_WIDTH-1:0] terms_reg, terms_next;
  logic [ACC_WIDTH-1:0]  result_reg, result_next;
  logic                  result_valid_reg, result_valid_next;
  logic                  overflow_reg, overflow_next;
  logic                  dropped_reg, dropped_next;

  logic [ACC_WIDTH-1:0]  add_sum;
  logic                  add_sat;
  logic [TERM_WIDTH-1:0] count_inc;
  logic                  start_ok;

  sat_adder #(
    .ACC_WIDTH     (ACC_WIDTH),
    .PRODUCT_WIDTH (PRODUCT_WIDTH)
  ) u_sat_adder (
    .acc     (acc_reg),
    .product (product),
    .sum     (add_sum),
    .sat     (add_sat)
  );

  assign count_inc = count_reg + TERM_WIDTH'(1);
  assign start_ok  = start && (num_terms != '0) && (num_terms <= MAX_TERMS_T);

  always_comb begin
    state_next        = state_reg;
    acc_next          = acc_reg;
    count_next        = count_reg;
    terms_next        = terms_reg;
    result_next       = result_reg;
    result_valid_next = result_valid_reg;
    overflow_next     = overflow_reg;
    dropped_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        dropped_next = product_valid;
        if (start_ok) begin
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
          terms_next    = num_terms;
          state_next    = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        // A valid start restarts the accumulation and swallows any product
        // arriving in the same cycle.
        if (start_ok) begin
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
          terms_next    = num_terms;
          dropped_next  = product_valid;
        end else if (product_valid) begin
          acc_next   = add_sum;
          count_next = count_inc;
          if (add_sat) begin
            overflow_next = 1'b1;
          end
          if (count_inc == terms_reg) begin
            result_next       = add_sum;
            result_valid_next = 1'b1;
            state_next        = ST_OUTPUT;
          end
        end
      end

      ST_OUTPUT: begin
        dropped_next = product_valid;
        if (result_ready) begin
          result_valid_next = 1'b0;
          state_next        = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      acc_reg          <= '0;
      count_reg        <= '0;
      terms_reg        <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      dropped_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      acc_reg          <= acc_next;
      count_reg        <= count_next;
      terms_reg        <= terms_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      overflow_reg     <= overflow_next;
      dropped_reg      <= dropped_next;
    end
  end

  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign busy         = (state_reg == ST_ACCUM);
  assign overflow     = overflow_reg;
  assign dropped      = dropped_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: directed scenarios plus randomized accumulations
// compared against a plain-arithmetic saturating-sum model.
module tb_mac_accumulator;

  localparam int PW = 8;
  localparam int MT = 16;
  localparam int TW = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_terms;
  logic [PW-1:0] product;
  logic          product_valid;
  logic          result_ready;

  logic [15:0] result;
  logic        result_valid, busy, overflow, dropped;
  logic [9:0]  result10;
  logic        result_valid10, busy10, overflow10, dropped10;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk (clk), .rst (rst), .start (start), .num_terms (num_terms),
    .product (product), .product_valid (product_valid),
    .result (result), .result_valid (result_valid), .result_ready (result_ready),
    .busy (busy), .overflow (overflow), .dropped (dropped)
  );

  mac_accumulator #(.ACC_WIDTH(10)) dut10 (
    .clk (clk), .rst (rst), .start (start), .num_terms (num_terms),
    .product (product), .product_valid (product_valid),
    .result (result10), .result_valid (result_valid10), .result_ready (result_ready),
    .busy (busy10), .overflow (overflow10), .dropped (dropped10)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; product_valid = 1'b0; result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); num_terms = '0; product = '0;
    tick(); tick();
    total_cnt++;
    if ({result, result_valid, busy, overflow, dropped} !== 20'h0)
      $display("FAIL reset_outputs: got res=%h rv=%b busy=%b ovf=%b drop=%b required all zero",
               result, result_valid, busy, overflow, dropped);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start = 1'b1; num_terms = 5'd2; tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else pass_cnt++;
    product = 8'h0E; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b0) $display("FAIL basic_early_valid: got %b required 0", result_valid); else pass_cnt++;
    product = 8'hE1; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 16'h00EF)
      $display("FAIL basic_result: got rv=%b res=%h required rv=1 res=00ef", result_valid, result);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_flags: got ovf=%b busy=%b required 0 0", overflow, busy);
    else pass_cnt++;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b0 || result !== 16'h00EF)
      $display("FAIL basic_accept: got rv=%b res=%h required rv=0 res=00ef", result_valid, result);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    start = 1'b1; num_terms = 5'd5; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      product = 8'hE1; product_valid = 1'b1; tick(); product_valid = 1'b0;
    end
    total_cnt++;
    if (result_valid10 !== 1'b1 || result10 !== 10'h3FF || overflow10 !== 1'b1)
      $display("FAIL sat_result10: got rv=%b res=%h ovf=%b required rv=1 res=3ff ovf=1",
               result_valid10, result10, overflow10);
    else pass_cnt++;
    total_cnt++;
    if (result !== 16'h0465 || overflow !== 1'b0)
      $display("FAIL sat_result16: got res=%h ovf=%b required res=0465 ovf=0", result, overflow);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (result_valid10 !== 1'b1 || result10 !== 10'h3FF)
        $display("FAIL sat_hold: cycle %0d got rv=%b res=%h required rv=1 res=3ff",
                 i, result_valid10, result10);
      else pass_cnt++;
    end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    total_cnt++;
    if (result_valid10 !== 1'b0 || overflow10 !== 1'b1)
      $display("FAIL sat_sticky: got rv=%b ovf=%b required rv=0 ovf=1", result_valid10, overflow10);
    else pass_cnt++;
  endtask

  task automatic test_drop_idle();
    product = 8'h0E; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (dropped !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_drop: got drop=%b busy=%b required 1 0", dropped, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dropped !== 1'b0) $display("FAIL idle_drop_pulse: got %b required 0", dropped); else pass_cnt++;
    start = 1'b1; num_terms = 5'd1; tick(); start = 1'b0;
    total_cnt++;
    if (overflow10 !== 1'b0) $display("FAIL ovf_clear_on_start: got %b required 0", overflow10); else pass_cnt++;
    product = 8'h07; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 16'h0007)
      $display("FAIL idle_then_run: got rv=%b res=%h required rv=1 res=0007", result_valid, result);
    else pass_cnt++;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1; num_terms = 5'd3; tick(); start = 1'b0;
    product = 8'h0E; product_valid = 1'b1; tick();
    // Restart with a product in the same cycle: the product must be dropped.
    start = 1'b1; num_terms = 5'd1; product = 8'h55; tick(); start = 1'b0; product_valid = 1'b0;
    total_cnt++;
    if (dropped !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL abort_drop: got drop=%b busy=%b rv=%b required 1 1 0", dropped, busy, result_valid);
    else pass_cnt++;
    product = 8'h02; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 16'h0002)
      $display("FAIL abort_result: got rv=%b res=%h required rv=1 res=0002", result_valid, result);
    else pass_cnt++;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; num_terms = 5'd1; tick(); start = 1'b0;
    product = 8'h33; product_valid = 1'b1; tick(); product_valid = 1'b0;
    // Start while holding a result is ignored even as it is accepted.
    start = 1'b1; num_terms = 5'd2; result_ready = 1'b1; tick(); idle_inputs();
    total_cnt++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 16'h0033)
      $display("FAIL b2b_output_start: got busy=%b rv=%b res=%h required 0 0 0033", busy, result_valid, result);
    else pass_cnt++;
    start = 1'b1; num_terms = 5'd1; tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || result !== 16'h0033)
      $display("FAIL b2b_restart: got busy=%b res=%h required 1 0033", busy, result);
    else pass_cnt++;
    product = 8'h44; product_valid = 1'b1; tick(); product_valid = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 16'h0044)
      $display("FAIL b2b_result: got rv=%b res=%h required rv=1 res=0044", result_valid, result);
    else pass_cnt++;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_random(input int trials);
    int unsigned prods[$];
    longint sum;
    logic [15:0] exp16;
    logic [9:0]  exp10;
    logic        ovf16, ovf10;
    int          n;
    for (int t = 0; t < trials; t++) begin
      n = int'($urandom_range(1, MT));
      prods.delete();
      for (int k = 0; k < n; k++)
        prods.push_back(($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255));
      sum = 0;
      foreach (prods[k]) sum += prods[k];
      ovf16 = (sum > 65535); exp16 = ovf16 ? 16'hFFFF : 16'(sum);
      ovf10 = (sum > 1023);  exp10 = ovf10 ? 10'h3FF  : 10'(sum);

      start = 1'b1; num_terms = TW'(n); tick(); start = 1'b0;
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        product = PW'(prods[k]); product_valid = 1'b1; tick(); product_valid = 1'b0;
      end
      total_cnt++;
      if (result_valid !== 1'b1 || result !== exp16 || overflow !== ovf16)
        $display("FAIL rand16 t%0d n=%0d: got rv=%b res=%h ovf=%b required rv=1 res=%h ovf=%b",
                 t, n, result_valid, result, overflow, exp16, ovf16);
      else pass_cnt++;
      total_cnt++;
      if (result_valid10 !== 1'b1 || result10 !== exp10 || overflow10 !== ovf10)
        $display("FAIL rand10 t%0d n=%0d: got rv=%b res=%h ovf=%b required rv=1 res=%h ovf=%b",
                 t, n, result_valid10, result10, overflow10, exp10, ovf10);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        product = 8'hFF; product_valid = 1'b1; tick(); product_valid = 1'b0;
        total_cnt++;
        if (dropped !== 1'b1 || result !== exp16 || result_valid !== 1'b1)
          $display("FAIL rand_output_drop t%0d: got drop=%b res=%h rv=%b required 1 %h 1",
                   t, dropped, result, result_valid, exp16);
        else pass_cnt++;
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      total_cnt++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp16)
        $display("FAIL rand_accept t%0d: got rv=%b busy=%b res=%h required 0 0 %h",
                 t, result_valid, busy, result, exp16);
      else pass_cnt++;
      $display("txn %0d: n=%0d sum=%0d res16=%h res10=%h", t, n, sum, result, result10);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; num_terms = 5'd3; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      product = 8'h21; product_valid = 1'b1; tick(); product_valid = 1'b0;
    end
    rst = 1'b1; start = 1'b1; num_terms = 5'd1; product_valid = 1'b1; result_ready = 1'b1;
    tick();
    rst = 1'b0; idle_inputs();
    total_cnt++;
    if ({result, result_valid, busy, overflow, dropped} !== 20'h0)
      $display("FAIL reset_mid: got res=%h rv=%b busy=%b ovf=%b drop=%b required all zero",
               result, result_valid, busy, overflow, dropped);
    else pass_cnt++;
    start = 1'b1; num_terms = 5'd0; tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL zero_terms_ignored: got busy=%b required 0", busy); else pass_cnt++;
    start = 1'b1; num_terms = 5'd20; tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL big_terms_ignored: got busy=%b required 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_drop_idle();
    test_abort();
    test_back_to_back();
    test_random(25);
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
